chess_turn_timer: RTL and testbench

//  Two-player chess clock and turn sequencer for the timed chess game.

---
 rtl/chess_timer_pkg.sv | 20 ++
 rtl/chess_second_tick.sv | 36 +++
 rtl/chess_turn_timer.sv | 149 ++++++++++++++
 tb/tb_chess_turn_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_timer_pkg.sv
// Shared constants for the chess turn timer: FSM state codes, player identities and key levels.
package chess_timer_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    localparam logic WHITE_PLAYER = 1'b1;
    localparam logic BLACK_PLAYER = 1'b0;

    localparam logic KEY_ON  = 1'b0;
    localparam logic KEY_OFF = 1'b1;

    // Active-low push key: a press is the released-to-pressed transition.
    function automatic logic key_pressed(input logic prev_level, input logic cur_level);
        return (prev_level == KEY_OFF) && (cur_level == KEY_ON);
    endfunction

endpackage

// File: rtl/chess_second_tick.sv
// One-second prescaler: counts while enabled, holds otherwise, and pulses tick on terminal count.
module chess_second_tick #(
    parameter int unsigned CLOCK_FREQUENCY = 50_000_000
) (
    input  logic clock,
    input  logic resetApp,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CountWidth = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(CLOCK_FREQUENCY - 1);

    logic [CountWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LastCount) ? '0 : count_q + CountWidth'(1);
        end
    end

    assign tick = enable && !clear && (count_q == LastCount);

    always_ff @(posedge clock) begin
        if (resetApp) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chess_turn_timer.sv
// Two-player chess clock: start/pause FSM, per-player second counters and flag-fall detection.
// Define CHESS_TIMER_INCREMENT_EN to credit INCREMENT_SECONDS to the side that just moved.
module chess_turn_timer
    import chess_timer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY   = 50_000_000,
    parameter int unsigned TIME_WIDTH        = 12,
    parameter int unsigned INITIAL_SECONDS   = 600,
    parameter int unsigned INCREMENT_SECONDS = 5
) (
    input  logic                  clock,
    input  logic                  resetApp,
    input  logic                  StartKey,
    input  logic                  PauseSwitch,
    input  logic                  Player,
    output logic [TIME_WIDTH-1:0] WhiteSeconds,
    output logic [TIME_WIDTH-1:0] BlackSeconds,
    output logic                  MoveEnable,
    output logic                  GameOver,
    output logic                  Loser,
    output logic [1:0]            State
);

`ifdef CHESS_TIMER_INCREMENT_EN
    localparam bit IncrementEn = 1'b1;
`else
    localparam bit IncrementEn = 1'b0;
`endif

    localparam logic [TIME_WIDTH-1:0] InitTime = TIME_WIDTH'(INITIAL_SECONDS);

    logic [1:0]            state_q, state_d;
    logic [TIME_WIDTH-1:0] white_q, white_d;
    logic [TIME_WIDTH-1:0] black_q, black_d;
    logic                  move_enable_q, move_enable_d;
    logic                  game_over_q, game_over_d;
    logic                  loser_q, loser_d;
    logic                  prev_player_q;
    logic                  start_key_q;

    logic                  running;
    logic                  press;
    logic                  turn_change;
    logic                  tick;
    logic                  flag_fall;
    logic [TIME_WIDTH-1:0] mover_time;

    function automatic logic [TIME_WIDTH-1:0] add_bonus(input logic [TIME_WIDTH-1:0] t);
        logic [TIME_WIDTH:0] sum;
        sum = {1'b0, t} + (TIME_WIDTH + 1)'(INCREMENT_SECONDS);
        return sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
    endfunction

    assign running     = (state_q == RUNNING);
    assign press       = key_pressed(start_key_q, StartKey);
    assign turn_change = (Player != prev_player_q);

    // A turn change restarts the second so the new mover gets a full one; it also masks the tick.
    chess_second_tick #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_second_tick (
        .clock   (clock),
        .resetApp(resetApp),
        .enable  (running),
        .clear   (running && turn_change),
        .tick    (tick)
    );

    assign mover_time = (Player == WHITE_PLAYER) ? white_q : black_q;
    assign flag_fall  = tick && (mover_time <= TIME_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        white_d = white_q;
        black_d = black_q;
        loser_d = loser_q;

        if (IncrementEn && running && turn_change) begin
            if (prev_player_q == WHITE_PLAYER) begin
                white_d = add_bonus(white_q);
            end else begin
                black_d = add_bonus(black_q);
            end
        end

        if (tick) begin
            if (Player == WHITE_PLAYER && white_q != '0) begin
                white_d = white_q - TIME_WIDTH'(1);
            end
            if (Player == BLACK_PLAYER && black_q != '0) begin
                black_d = black_q - TIME_WIDTH'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (press) state_d = RUNNING;
            end
            RUNNING: begin
                // Flag fall outranks a simultaneous pause request.
                if (flag_fall) begin
                    state_d = TIMEOUT;
                    loser_d = Player;
                end else if (PauseSwitch) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (press && !PauseSwitch) state_d = RUNNING;
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
        endcase

        move_enable_d = (state_d == RUNNING);
        game_over_d   = (state_d == TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (resetApp) begin
            state_q       <= IDLE;
            white_q       <= InitTime;
            black_q       <= InitTime;
            move_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
            loser_q       <= BLACK_PLAYER;
            prev_player_q <= Player;
            start_key_q   <= KEY_OFF;
        end else begin
            state_q       <= state_d;
            white_q       <= white_d;
            black_q       <= black_d;
            move_enable_q <= move_enable_d;
            game_over_q   <= game_over_d;
            loser_q       <= loser_d;
            prev_player_q <= Player;
            start_key_q   <= StartKey;
        end
    end

    assign WhiteSeconds = white_q;
    assign BlackSeconds = black_q;
    assign MoveEnable   = move_enable_q;
    assign GameOver     = game_over_q;
    assign Loser        = loser_q;
    assign State        = state_q;

endmodule

// File: tb/tb_chess_turn_timer.sv
// Directed bench for chess_turn_timer with a game-level reference model checked every cycle.
module tb_chess_turn_timer;

    localparam int unsigned CF   = 10;
    localparam int unsigned TW   = 12;
    localparam int unsigned INIT = 3;
    localparam int unsigned INC  = 2;
    localparam int          TMAX = (1 << TW) - 1;

`ifdef CHESS_TIMER_INCREMENT_EN
    localparam bit IncEn = 1'b1;
`else
    localparam bit IncEn = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OUT = 3;

    logic          clk = 1'b0;
    logic          resetApp, StartKey, PauseSwitch, Player;
    logic [TW-1:0] WhiteSeconds, BlackSeconds;
    logic          MoveEnable, GameOver, Loser;
    logic [1:0]    State;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    chess_turn_timer #(
        .CLOCK_FREQUENCY  (CF),
        .TIME_WIDTH       (TW),
        .INITIAL_SECONDS  (INIT),
        .INCREMENT_SECONDS(INC)
    ) dut (
        .clock       (clk),
        .resetApp    (resetApp),
        .StartKey    (StartKey),
        .PauseSwitch (PauseSwitch),
        .Player      (Player),
        .WhiteSeconds(WhiteSeconds),
        .BlackSeconds(BlackSeconds),
        .MoveEnable  (MoveEnable),
        .GameOver    (GameOver),
        .Loser       (Loser),
        .State       (State)
    );

    always #5 clk = ~clk;

    // Game-level model: mode, seconds per side (index = player), elapsed running cycles this second.
    int m_mode;
    int m_time [2];
    int m_frac;
    bit m_prev, m_key, m_loser, m_valid = 1'b0;
    bit pressed, moved;

    always @(posedge clk) begin
        cycle++;
        if (resetApp) begin
            m_mode    = M_IDLE;
            m_time[0] = INIT;
            m_time[1] = INIT;
            m_frac    = 0;
            m_prev    = Player;
            m_key     = 1'b1;
            m_loser   = 1'b0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            pressed = m_key && !StartKey;
            moved   = (Player != m_prev);
            case (m_mode)
                M_IDLE: if (pressed) m_mode = M_RUN;
                M_RUN: begin
                    if (moved) begin
                        m_frac = 0;
                        if (IncEn) begin
                            m_time[m_prev] = m_time[m_prev] + INC;
                            if (m_time[m_prev] > TMAX) m_time[m_prev] = TMAX;
                        end
                    end else if (m_frac == CF - 1) begin
                        m_frac = 0;
                        if (m_time[Player] > 0) m_time[Player] = m_time[Player] - 1;
                        if (m_time[Player] == 0) begin
                            m_mode  = M_OUT;
                            m_loser = Player;
                        end
                    end else begin
                        m_frac = m_frac + 1;
                    end
                    if (m_mode == M_RUN && PauseSwitch) m_mode = M_PAUSE;
                end
                M_PAUSE: if (pressed && !PauseSwitch) m_mode = M_RUN;
                default: ;
            endcase
            m_prev = Player;
            m_key  = StartKey;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (State !== 2'(m_mode) || WhiteSeconds !== TW'(m_time[1])
                || BlackSeconds !== TW'(m_time[0]) || MoveEnable !== (m_mode == M_RUN)
                || GameOver !== (m_mode == M_OUT) || Loser !== m_loser) begin
                miscompares++;
                $display("FAIL model cycle %0d: got S=%0d W=%0d B=%0d ME=%b GO=%b L=%b, want S=%0d W=%0d B=%0d ME=%b GO=%b L=%b",
                         cycle, State, WhiteSeconds, BlackSeconds, MoveEnable, GameOver, Loser,
                         m_mode, m_time[1], m_time[0], m_mode == M_RUN, m_mode == M_OUT, m_loser);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key();
        StartKey = 1'b0;
        cyc(1);
        StartKey = 1'b1;
    endtask

    initial begin
        resetApp = 1'b1; StartKey = 1'b1; PauseSwitch = 1'b0; Player = 1'b1;
        cyc(2);
        resetApp = 1'b0;
        cyc(1);
        check_lit("reset state", State, 0);
        check_lit("reset white", WhiteSeconds, 3);
        check_lit("reset black", BlackSeconds, 3);
        check_lit("reset moveenable", MoveEnable, 0);
        check_lit("reset gameover", GameOver, 0);

        // Start with white to move
        press_key();
        check_lit("start state", State, 1);
        check_lit("start moveenable", MoveEnable, 1);
        cyc(9);
        check_lit("white before first tick", WhiteSeconds, 3);
        cyc(1);
        check_lit("white after 10 cycles", WhiteSeconds, 2);
        check_lit("black untouched", BlackSeconds, 3);
        check_lit("model white after 10 cycles", m_time[1], 2);

        // Turn change at prescaler=7
        cyc(7);
        Player = 1'b0;
        cyc(1);
        check_lit("no white decrement on turn change", WhiteSeconds, IncEn ? 4 : 2);
        cyc(9);
        check_lit("black before full second", BlackSeconds, 3);
        cyc(1);
        check_lit("black 10 cycles after toggle", BlackSeconds, 2);

        // Pause for 25 cycles; a press while still paused is ignored
        cyc(4);
        PauseSwitch = 1'b1;
        cyc(1);
        check_lit("paused state", State, 2);
        check_lit("paused moveenable", MoveEnable, 0);
        cyc(10);
        press_key();
        check_lit("press ignored while pause held", State, 2);
        cyc(13);
        check_lit("black frozen in pause", BlackSeconds, 2);
        PauseSwitch = 1'b0;
        cyc(1);
        press_key();
        check_lit("resumed state", State, 1);
        cyc(4);
        check_lit("black before resumed tick", BlackSeconds, 2);
        cyc(1);
        check_lit("prescaler kept across pause", BlackSeconds, 1);

        // White runs out
        Player = 1'b1;
        cyc(1);
        cyc(19);
        check_lit("white at one", WhiteSeconds, IncEn ? 3 : 1);
        if (IncEn) cyc(20);
        cyc(1);
        check_lit("white flag", WhiteSeconds, 0);
        check_lit("timeout state", State, 3);
        check_lit("timeout gameover", GameOver, 1);
        check_lit("timeout loser white", Loser, 1);
        check_lit("timeout moveenable", MoveEnable, 0);
        press_key();
        cyc(15);
        check_lit("timeout absorbing", State, 3);
        check_lit("white stays at zero", WhiteSeconds, 0);

        // Reset from TIMEOUT
        resetApp = 1'b1;
        cyc(1);
        resetApp = 1'b0;
        check_lit("reset from timeout state", State, 0);
        check_lit("reset from timeout white", WhiteSeconds, 3);
        check_lit("reset from timeout gameover", GameOver, 0);

        // Turn change coinciding with tick
        press_key();
        cyc(9);
        Player = 1'b0;
        cyc(1);
        check_lit("tick plus turn white", WhiteSeconds, IncEn ? 5 : 3);
        check_lit("tick plus turn black", BlackSeconds, 3);

        // Black flag falls in the same cycle as a pause request
        cyc(20);
        check_lit("black at one", BlackSeconds, 1);
        cyc(9);
        PauseSwitch = 1'b1;
        cyc(1);
        check_lit("timeout beats pause", State, 3);
        check_lit("loser black", Loser, 0);
        PauseSwitch = 1'b0;

        // Reset from PAUSED
        resetApp = 1'b1;
        cyc(1);
        resetApp = 1'b0;
        press_key();
        PauseSwitch = 1'b1;
        cyc(3);
        check_lit("paused before reset", State, 2);
        resetApp = 1'b1;
        cyc(1);
        resetApp = 1'b0;
        PauseSwitch = 1'b0;
        check_lit("reset from pause state", State, 0);
        check_lit("reset from pause black", BlackSeconds, 3);
        check_lit("reset from pause moveenable", MoveEnable, 0);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
